// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES inverse-cipher byte and state helpers
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (b)
            8'h00: r=8'h52; 8'h01: r=8'h09; 8'h02: r=8'h6a; 8'h03: r=8'hd5; 8'h04: r=8'h30; 8'h05: r=8'h36; 8'h06: r=8'ha5; 8'h07: r=8'h38; 8'h08: r=8'hbf; 8'h09: r=8'h40; 8'h0a: r=8'ha3; 8'h0b: r=8'h9e; 8'h0c: r=8'h81; 8'h0d: r=8'hf3; 8'h0e: r=8'hd7; 8'h0f: r=8'hfb;
            8'h10: r=8'h7c; 8'h11: r=8'he3; 8'h12: r=8'h39; 8'h13: r=8'h82; 8'h14: r=8'h9b; 8'h15: r=8'h2f; 8'h16: r=8'hff; 8'h17: r=8'h87; 8'h18: r=8'h34; 8'h19: r=8'h8e; 8'h1a: r=8'h43; 8'h1b: r=8'h44; 8'h1c: r=8'hc4; 8'h1d: r=8'hde; 8'h1e: r=8'he9; 8'h1f: r=8'hcb;
            8'h20: r=8'h54; 8'h21: r=8'h7b; 8'h22: r=8'h94; 8'h23: r=8'h32; 8'h24: r=8'ha6; 8'h25: r=8'hc2; 8'h26: r=8'h23; 8'h27: r=8'h3d; 8'h28: r=8'hee; 8'h29: r=8'h4c; 8'h2a: r=8'h95; 8'h2b: r=8'h0b; 8'h2c: r=8'h42; 8'h2d: r=8'hfa; 8'h2e: r=8'hc3; 8'h2f: r=8'h4e;
            8'h30: r=8'h08; 8'h31: r=8'h2e; 8'h32: r=8'ha1; 8'h33: r=8'h66; 8'h34: r=8'h28; 8'h35: r=8'hd9; 8'h36: r=8'h24; 8'h37: r=8'hb2; 8'h38: r=8'h76; 8'h39: r=8'h5b; 8'h3a: r=8'ha2; 8'h3b: r=8'h49; 8'h3c: r=8'h6d; 8'h3d: r=8'h8b; 8'h3e: r=8'hd1; 8'h3f: r=8'h25;
            8'h40: r=8'h72; 8'h41: r=8'hf8; 8'h42: r=8'hf6; 8'h43: r=8'h64; 8'h44: r=8'h86; 8'h45: r=8'h68; 8'h46: r=8'h98; 8'h47: r=8'h16; 8'h48: r=8'hd4; 8'h49: r=8'ha4; 8'h4a: r=8'h5c; 8'h4b: r=8'hcc; 8'h4c: r=8'h5d; 8'h4d: r=8'h65; 8'h4e: r=8'hb6; 8'h4f: r=8'h92;
            8'h50: r=8'h6c; 8'h51: r=8'h70; 8'h52: r=8'h48; 8'h53: r=8'h50; 8'h54: r=8'hfd; 8'h55: r=8'hed; 8'h56: r=8'hb9; 8'h57: r=8'hda; 8'h58: r=8'h5e; 8'h59: r=8'h15; 8'h5a: r=8'h46; 8'h5b: r=8'h57; 8'h5c: r=8'ha7; 8'h5d: r=8'h8d; 8'h5e: r=8'h9d; 8'h5f: r=8'h84;
            8'h60: r=8'h90; 8'h61: r=8'hd8; 8'h62: r=8'hab; 8'h63: r=8'h00; 8'h64: r=8'h8c; 8'h65: r=8'hbc; 8'h66: r=8'hd3; 8'h67: r=8'h0a; 8'h68: r=8'hf7; 8'h69: r=8'he4; 8'h6a: r=8'h58; 8'h6b: r=8'h05; 8'h6c: r=8'hb8; 8'h6d: r=8'hb3; 8'h6e: r=8'h45; 8'h6f: r=8'h06;
            8'h70: r=8'hd0; 8'h71: r=8'h2c; 8'h72: r=8'h1e; 8'h73: r=8'h8f; 8'h74: r=8'hca; 8'h75: r=8'h3f; 8'h76: r=8'h0f; 8'h77: r=8'h02; 8'h78: r=8'hc1; 8'h79: r=8'haf; 8'h7a: r=8'hbd; 8'h7b: r=8'h03; 8'h7c: r=8'h01; 8'h7d: r=8'h13; 8'h7e: r=8'h8a; 8'h7f: r=8'h6b;
            8'h80: r=8'h3a; 8'h81: r=8'h91; 8'h82: r=8'h11; 8'h83: r=8'h41; 8'h84: r=8'h4f; 8'h85: r=8'h67; 8'h86: r=8'hdc; 8'h87: r=8'hea; 8'h88: r=8'h97; 8'h89: r=8'hf2; 8'h8a: r=8'hcf; 8'h8b: r=8'hce; 8'h8c: r=8'hf0; 8'h8d: r=8'hb4; 8'h8e: r=8'he6; 8'h8f: r=8'h73;
            8'h90: r=8'h96; 8'h91: r=8'hac; 8'h92: r=8'h74; 8'h93: r=8'h22; 8'h94: r=8'he7; 8'h95: r=8'had; 8'h96: r=8'h35; 8'h97: r=8'h85; 8'h98: r=8'he2; 8'h99: r=8'hf9; 8'h9a: r=8'h37; 8'h9b: r=8'he8; 8'h9c: r=8'h1c; 8'h9d: r=8'h75; 8'h9e: r=8'hdf; 8'h9f: r=8'h6e;
            8'ha0: r=8'h47; 8'ha1: r=8'hf1; 8'ha2: r=8'h1a; 8'ha3: r=8'h71; 8'ha4: r=8'h1d; 8'ha5: r=8'h29; 8'ha6: r=8'hc5; 8'ha7: r=8'h89; 8'ha8: r=8'h6f; 8'ha9: r=8'hb7; 8'haa: r=8'h62; 8'hab: r=8'h0e; 8'hac: r=8'haa; 8'had: r=8'h18; 8'hae: r=8'hbe; 8'haf: r=8'h1b;
            8'hb0: r=8'hfc; 8'hb1: r=8'h56; 8'hb2: r=8'h3e; 8'hb3: r=8'h4b; 8'hb4: r=8'hc6; 8'hb5: r=8'hd2; 8'hb6: r=8'h79; 8'hb7: r=8'h20; 8'hb8: r=8'h9a; 8'hb9: r=8'hdb; 8'hba: r=8'hc0; 8'hbb: r=8'hfe; 8'hbc: r=8'h78; 8'hbd: r=8'hcd; 8'hbe: r=8'h5a; 8'hbf: r=8'hf4;
            8'hc0: r=8'h1f; 8'hc1: r=8'hdd; 8'hc2: r=8'ha8; 8'hc3: r=8'h33; 8'hc4: r=8'h88; 8'hc5: r=8'h07; 8'hc6: r=8'hc7; 8'hc7: r=8'h31; 8'hc8: r=8'hb1; 8'hc9: r=8'h12; 8'hca: r=8'h10; 8'hcb: r=8'h59; 8'hcc: r=8'h27; 8'hcd: r=8'h80; 8'hce: r=8'hec; 8'hcf: r=8'h5f;
            8'hd0: r=8'h60; 8'hd1: r=8'h51; 8'hd2: r=8'h7f; 8'hd3: r=8'ha9; 8'hd4: r=8'h19; 8'hd5: r=8'hb5; 8'hd6: r=8'h4a; 8'hd7: r=8'h0d; 8'hd8: r=8'h2d; 8'hd9: r=8'he5; 8'hda: r=8'h7a; 8'hdb: r=8'h9f; 8'hdc: r=8'h93; 8'hdd: r=8'hc9; 8'hde: r=8'h9c; 8'hdf: r=8'hef;
            8'he0: r=8'ha0; 8'he1: r=8'he0; 8'he2: r=8'h3b; 8'he3: r=8'h4d; 8'he4: r=8'hae; 8'he5: r=8'h2a; 8'he6: r=8'hf5; 8'he7: r=8'hb0; 8'he8: r=8'hc8; 8'he9: r=8'heb; 8'hea: r=8'hbb; 8'heb: r=8'h3c; 8'hec: r=8'h83; 8'hed: r=8'h53; 8'hee: r=8'h99; 8'hef: r=8'h61;
            8'hf0: r=8'h17; 8'hf1: r=8'h2b; 8'hf2: r=8'h04; 8'hf3: r=8'h7e; 8'hf4: r=8'hba; 8'hf5: r=8'h77; 8'hf6: r=8'hd6; 8'hf7: r=8'h26; 8'hf8: r=8'he1; 8'hf9: r=8'h69; 8'hfa: r=8'h14; 8'hfb: r=8'h63; 8'hfc: r=8'h55; 8'hfd: r=8'h21; 8'hfe: r=8'h0c; 8'hff: r=8'h7d;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] st);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(st[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    // Byte 4c+r holds row r, column c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = st[127 - 32*c -: 8];
            a1 = st[119 - 32*c -: 8];
            a2 = st[111 - 32*c -: 8];
            a3 = st[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
            o[119 - 32*c -: 8] = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
            o[111 - 32*c -: 8] = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
            o[103 - 32*c -: 8] = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round_2stage.sv
// rtl/aes_inv_round_2stage.sv - one AES inverse round split over two registered stages
module aes_inv_round_2stage
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         sel_inv_mix_col,
    output logic [127:0] state_out
);

    logic [127:0] sub_d, sub_q;
    logic [127:0] mix_d, mix_q;
    logic [127:0] ark;

    always_comb begin
        sub_d = inv_sub_bytes(inv_shift_rows(state_in));
        ark   = sub_q ^ round_key;
        mix_d = sel_inv_mix_col ? inv_mix_columns(ark) : ark;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= '0;
            mix_q <= '0;
        end else begin
            sub_q <= sub_d;
            mix_q <= mix_d;
        end
    end

    assign state_out = mix_q;

endmodule

// File: rtl/aes_unrolled_pipelined_decrypt.sv
// rtl/aes_unrolled_pipelined_decrypt.sv - unrolled, fully pipelined AES inverse cipher with sideband tag
module aes_unrolled_pipelined_decrypt
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [127:0]          ciphertext,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [(NR+1)*128-1:0] round_keys_flat,
    output logic                  out_valid,
    output logic [127:0]          plaintext,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int VW = 2*NR + 2;

    logic [NR:0][127:0]         rk;
    logic [NR:0][127:0]         stage;
    logic [127:0]               s0_d, s0_q;
    logic [VW-1:0]              valid_d, valid_q;
    logic [2*NR:0][TAG_W-1:0]   tag_d, tag_q;
    logic [127:0]               pt_d, pt_q;
    logic [TAG_W-1:0]           otag_d, otag_q;

    assign rk       = round_keys_flat;
    assign stage[0] = s0_q;

    // Round g+1 uses key NR-1-g; only the last round skips InvMixColumns.
    for (genvar g = 0; g < NR; g++) begin : g_round
        aes_inv_round_2stage u_round (
            .clk             (clk),
            .rst_n           (rst_n),
            .state_in        (stage[g]),
            .round_key       (rk[NR-1-g]),
            .sel_inv_mix_col (g != NR - 1),
            .state_out       (stage[g+1])
        );
    end

    // Tag slot k is aligned with valid bit k, so the output stage samples both together.
    always_comb begin
        s0_d       = in_valid ? (ciphertext ^ rk[NR]) : s0_q;
        valid_d    = {valid_q[VW-2:0], in_valid};
        tag_d[0]   = in_valid ? in_tag : tag_q[0];
        tag_d[2*NR:1] = tag_q[2*NR-1:0];
        pt_d       = valid_q[2*NR] ? stage[NR]    : pt_q;
        otag_d     = valid_q[2*NR] ? tag_q[2*NR]  : otag_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q    <= '0;
            valid_q <= '0;
            tag_q   <= '0;
            pt_q    <= '0;
            otag_q  <= '0;
        end else begin
            s0_q    <= s0_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            pt_q    <= pt_d;
            otag_q  <= otag_d;
        end
    end

    assign out_valid = valid_q[VW-1];
    assign plaintext = pt_q;
    assign out_tag   = otag_q;

endmodule

// File: tb/tb_aes_unrolled_pipelined_decrypt.sv
// tb/tb_aes_unrolled_pipelined_decrypt.sv - scoreboard bench for the AES-128/192/256 decrypt pipelines
module tb_aes_unrolled_pipelined_decrypt;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [3:0]        in_tag;
    logic [2:0][127:0] ct_i;
    logic [2:0]        ov;
    logic [2:0][127:0] pt_o;
    logic [2:0][3:0]   tag_o;
    logic [1919:0]     rkf [3];
    logic [2:0][127:0] kat_ct;

    int nrs [3] = '{10, 12, 14};
    int cyc;
    int checks;
    int errors;

    logic [7:0]   sb [256];
    int           exp_due [3][64];
    int           exp_iss [3][64];
    logic [127:0] exp_pt  [3][64];
    logic [3:0]   exp_tag [3][64];
    logic [127:0] last_pt  [3];
    logic [3:0]   last_tag [3];
    int           rst_cyc;
    int           slot;
    bit           live;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    aes_unrolled_pipelined_decrypt #(.NR(10), .TAG_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ciphertext(ct_i[0]), .in_tag(in_tag),
        .round_keys_flat(rkf[0][1407:0]), .out_valid(ov[0]), .plaintext(pt_o[0]), .out_tag(tag_o[0]));
    aes_unrolled_pipelined_decrypt #(.NR(12), .TAG_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ciphertext(ct_i[1]), .in_tag(in_tag),
        .round_keys_flat(rkf[1][1663:0]), .out_valid(ov[1]), .plaintext(pt_o[1]), .out_tag(tag_o[1]));
    aes_unrolled_pipelined_decrypt #(.NR(14), .TAG_W(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ciphertext(ct_i[2]), .in_tag(in_tag),
        .round_keys_flat(rkf[2]), .out_valid(ov[2]), .plaintext(pt_o[2]), .out_tag(tag_o[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Generic FIPS-197 key expansion; key is left-aligned in 256 bits.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] flat;
        int nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        flat = '0;
        for (int i = 0; i < 4*(nr+1); i++) flat[(i/4)*128 + (3 - i%4)*32 +: 32] = w[i];
        return flat;
    endfunction

    // Forward cipher: the decryptor must undo exactly this.
    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1919:0] rk, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, o;
        k = rk[127:0];
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[w + 4*c] = t[w + 4*((c + w) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            k = rk[r*128 +: 128];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string nm, input int d, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, d, cyc, got, want);
        end
    endtask

    // One input cycle; a valid block is scheduled to emerge 2*NR+2 cycles after it is driven.
    task automatic step(input bit v, input logic [127:0] p, input logic [3:0] tg, input bit kat);
        int due;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = v;
        in_tag   = v ? tg : 4'($urandom);
        for (int d = 0; d < 3; d++) begin
            if (!v)       ct_i[d] = {$urandom, $urandom, $urandom, $urandom};
            else if (kat) ct_i[d] = kat_ct[d];
            else          ct_i[d] = enc(p, rkf[d], nrs[d]);
            if (v) begin
                due = cyc + 2*nrs[d] + 2;
                exp_due[d][due % 64] = due;
                exp_iss[d][due % 64] = cyc;
                exp_pt[d][due % 64]  = p;
                exp_tag[d][due % 64] = tg;
            end
        end
    endtask

    task automatic reset_cycle();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_tag   = 4'($urandom);
        for (int d = 0; d < 3; d++) ct_i[d] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            slot = cyc % 64;
            live = (exp_due[d][slot] == cyc) && (exp_iss[d][slot] > rst_cyc);
            chk("out_valid", d, {127'b0, ov[d]}, {127'b0, live});
            if (live) begin
                last_pt[d]  = exp_pt[d][slot];
                last_tag[d] = exp_tag[d][slot];
            end
            chk("plaintext", d, pt_o[d], last_pt[d]);
            chk("out_tag", d, {124'b0, tag_o[d]}, {124'b0, last_tag[d]});
        end
        if (!rst_n) begin
            rst_cyc = cyc;
            for (int d = 0; d < 3; d++) begin
                last_pt[d]  = '0;
                last_tag[d] = '0;
            end
        end
    end

    initial begin
        logic [7:0] inv;
        cyc = 0; checks = 0; errors = 0; rst_cyc = -1;
        rst_n = 1'b0; in_valid = 1'b0; in_tag = '0; ct_i = '0;
        for (int d = 0; d < 3; d++) begin
            last_pt[d] = '0; last_tag[d] = '0;
            for (int s = 0; s < 64; s++) begin
                exp_due[d][s] = -1; exp_iss[d][s] = -1;
                exp_pt[d][s] = '0; exp_tag[d][s] = '0;
            end
        end
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) if (gmul(i[7:0], j[7:0]) == 8'h01) inv = j[7:0];
            sb[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        rkf[0] = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
        rkf[1] = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
        rkf[2] = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
        kat_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

        chk("model_sbox_00", 0, {120'b0, sb[8'h00]}, 128'h63);
        chk("model_sbox_53", 0, {120'b0, sb[8'h53]}, 128'hed);
        for (int d = 0; d < 3; d++) chk("model_kat", d, enc(FIPS_PT, rkf[d], nrs[d]), kat_ct[d]);

        repeat (3) reset_cycle();
        step(1'b1, FIPS_PT, 4'd3, 1'b1);
        repeat (32) step(1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 64; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'(i % 16), 1'b0);
        for (int r = 0; r < 2; r++)
            foreach (nrs[k]) begin end
        for (int r = 0; r < 2; r++) begin
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0);
            step(1'b0, '0, '0, 1'b0);
            step(1'b0, '0, '0, 1'b0);
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0);
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0);
            step(1'b0, '0, '0, 1'b0);
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0);
        end
        repeat (35) step(1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'(i + 1), 1'b0);
        reset_cycle();
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, FIPS_PT, 4'd9, 1'b1);
        repeat (35) step(1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 1000; i++)
            step(($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0);
        repeat (40) step(1'b0, '0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_unrolled_pipelined_decrypt.md
Name: aes_unrolled_pipelined_decrypt

Overview:
Fully unrolled, fully pipelined AES inverse cipher (FIPS-197 InvCipher) that accepts one 128-bit ciphertext per cycle and returns the plaintext after a fixed latency. It is the decrypt counterpart of the team's unrolled pipelined encrypt core. It consumes the same flat, pre-expanded round-key bus and sits behind the AXI wrapper alongside the encrypt core. A sideband tag travels with each block so the wrapper can match results to requests.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256).
TAG_W, 4, width of the sideband tag carried alongside each block.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  ciphertext/tag are valid this cycle; no backpressure.
ciphertext  input  128  input block; byte 0 = [127:120], column-major state (s[0,0] = byte 0).
in_tag  input  TAG_W  sideband tag, sampled with in_valid.
round_keys_flat  input  (NR+1)*128  expanded keys; key k = bits [k*128 +: 128]; key 0 = cipher key. Quasi-static: changes only while the pipeline is empty.
out_valid  output  1  plaintext/out_tag valid this cycle.
plaintext  output  128  decrypted block, same byte order as the input.
out_tag  output  TAG_W  tag that entered with this block.

Behaviour:
- Reset: synchronous. When rst_n is low at a rising edge, every pipeline register, the valid shift register, the tag pipe, plaintext, out_valid and out_tag go to 0.
- Stage 0 (ARK): if in_valid, s0 <= ciphertext ^ rk[NR] and tag0 <= in_tag. Otherwise s0 and tag0 hold their values.
- Inverse round i, for i = 1..NR, is two registered stages:
  - Stage A: InvShiftRows then InvSubBytes.
  - Stage B: AddRoundKey with rk[NR-i], then InvMixColumns. InvMixColumns is bypassed when i = NR.
  - Round stages are free-running (no enable). Data in stages not marked valid is don't-care and never reaches the outputs.
- Output stage: plaintext and out_tag load from round NR stage B only when the matching valid bit is 1. Otherwise they hold the last valid result.
- Latency: a block sampled with in_valid at edge N appears with out_valid = 1 after edge N + 2*NR + 2. For NR = 10 that is 22 cycles.
- Valid pipe: a (2*NR+2)-bit shift register, cleared on reset. out_valid is its MSB.
- Throughput: 1 block per cycle. Any mix of back-to-back and gapped in_valid is supported, and output order equals input order.
- Tag pipe: tags are shifted alongside the valid pipe and are bit-exact with their block.
- Reset mid-stream: all in-flight blocks are discarded. No out_valid is produced for them. The first block accepted after rst_n rises comes out with normal latency.
- in_valid is ignored while rst_n is low.
- When in_valid is 0, changes on ciphertext and in_tag must have no effect on any output.
- Changing round_keys_flat while blocks are in flight gives undefined results for those blocks only. No lock-up follows.

Decomposition:
- aes_pkg holds:
  - inverse S-box function (256-entry case);
  - GF(2^8) xtime and mul-by-{09,0b,0d,0e} functions;
  - inv_shift_rows and inv_mix_columns functions;
  - localparams NR_128 = 10, NR_192 = 12, NR_256 = 14.
- Sub-module aes_inv_round_2stage:
  - ports: clk, rst_n, state_in, round_key, sel_inv_mix_col, state_out;
  - contains the two registers with synchronous reset;
  - instantiated NR times in a generate loop, with sel_inv_mix_col = 0 on the final instance.
- Top level holds the key slicer, stage 0, the output stage, and the valid and tag pipes.

Test Plan:
1. NR=10, key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, tag 3 -> exactly 22 cycles later out_valid = 1 for one cycle, plaintext = 00112233445566778899aabbccddeeff, out_tag = 3.
2. NR=12 key 000102…1617 and NR=14 key 000102…1e1f; ciphertexts dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233445566778899aabbccddeeff, latency 26 and 30 cycles respectively.
3. Back-to-back, 64 random blocks on consecutive cycles with tags 0..15 repeating -> 64 consecutive out_valid cycles, each matching the encrypt-core/reference-model result in order with the correct tags.
4. Gapped in_valid pattern 1,0,0,1,1,0,1 while ciphertext and in_tag toggle randomly in the invalid cycles -> out_valid reproduces the pattern delayed by 22 cycles; plaintext holds its previous value in gap cycles.
5. Reset mid-stream: 10 blocks in flight, rst_n low for 1 cycle -> the next cycle shows plaintext = 0, out_tag = 0, out_valid = 0; no stale out_valid ever appears; a block issued 1 cycle after release decodes correctly at latency 22.
6. Loopback: encrypt-core output fed into this block with the same keys, 1000 random blocks -> output equals the original plaintext and tag; zero mismatches.
